// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: response-owner
// states and the default data width.
package mem_arbiter_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I_RD = 2'd1,
        OWN_D_RD = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Fetch/data priority: data wins unless a waiting fetch has already been
// passed over STARVE_LIMIT times in a row.
module arb_prio #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       i_req,
    input  logic       d_req,
    input  logic [3:0] streak,
    output logic       gnt_i,
    output logic       gnt_d
);

    logic w_under_limit;

    assign w_under_limit = (streak < 4'(STARVE_LIMIT));
    assign gnt_d         = d_req & (~i_req | w_under_limit);
    assign gnt_i         = i_req & ~gnt_d;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store,
// with one-cycle read latency and fetch-flush suppression of responses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEFAULT,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [31:0]     i_addr,
    input  logic            i_flush,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    output logic            fetch_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [31:0]     d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    owner_e     r_owner;
    owner_e     w_owner_nxt;
    logic [3:0] r_streak;
    logic [3:0] w_streak_nxt;
    logic       w_arb_gnt_i;
    logic       w_arb_gnt_d;

    arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_prio (
        .i_req  (i_req),
        .d_req  (d_req),
        .streak (r_streak),
        .gnt_i  (w_arb_gnt_i),
        .gnt_d  (w_arb_gnt_d)
    );

    // Grants are masked during reset so no access leaks out regardless of requests.
    assign i_gnt       = w_arb_gnt_i & ~reset;
    assign d_gnt       = w_arb_gnt_d & ~reset;
    assign fetch_stall = i_req & ~i_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = i_addr;
        end
    end

    always_comb begin
        w_streak_nxt = r_streak;
        if (!i_req || i_gnt) begin
            w_streak_nxt = '0;
        end else if (d_gnt && (r_streak < 4'(STARVE_LIMIT))) begin
            w_streak_nxt = r_streak + 4'd1;
        end
    end

    // A fetch granted in a flush cycle is recorded as NONE so its data is dropped.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (i_gnt && !i_flush) begin
            w_owner_nxt = OWN_I_RD;
        end else if (d_gnt && !d_we) begin
            w_owner_nxt = OWN_D_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner  <= OWN_NONE;
            r_streak <= '0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    assign i_rvalid = (r_owner == OWN_I_RD) & ~i_flush & ~reset;
    assign d_rvalid = (r_owner == OWN_D_RD) & ~reset;
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule
